imem_fetch_sequencer: RTL and testbench
=======================================

// Module: imem_fetch_sequencer
// PURPOSE
//  Sequences the byte-wide, single-port instruction memory. Fetches each 32-bit instruction as four
//  big-endian byte reads and holds it for decode under a valid/ready handshake.
//  Sits between the PC/branch logic and decode. Owns the fetch PC.
//  Accepts redirects from branch/jump resolution.
// PARAMETERS
//  ADDR_W    8       byte-address width of instruction memory (256 bytes default)
//  RESET_PC  32'h0   fetch address loaded on reset
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high reset
//  mem_addr       out  ADDR_W  byte address to instruction memory
//  mem_rd_en      out  1       high in cycles where mem_addr is a live read
//  mem_data       in   8       byte at mem_addr, combinational (valid same cycle)
//  instr_out      out  32      assembled instruction {b0,b1,b2,b3}, b0 at lowest address
//  instr_pc       out  32      byte address of instr_out
//  instr_valid    out  1       instr_out/instr_pc hold a complete instruction
//  instr_ready    in   1       decode accepts instruction this cycle
//  redirect_valid in   1       change fetch stream this cycle
//  redirect_pc    in   32      new fetch address
//  align_err      out  1       sticky: a redirect_pc had [1:0]!=0
// BEHAVIOUR
//  Reset: state=BYTE0, pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, align_err=0.
//  - Reset has priority over every other input.
//  FSM states: BYTE0, BYTE1, BYTE2, BYTE3, HOLD.
//  BYTEk (k=0..3):
//  - mem_rd_en=1; mem_addr = pc[ADDR_W-1:0]+k (mod 2^ADDR_W).
//  - At the edge, mem_data is captured into byte lane k; state advances to BYTE(k+1).
//  - BYTE3 edge: instr_out <= {b0,b1,b2,mem_data}, instr_pc <= pc, instr_valid <= 1, state <= HOLD.
//  HOLD:
//  - mem_rd_en=0; mem_addr holds pc[ADDR_W-1:0]; instr_out/instr_pc stable.
//  - Handshake: transfer occurs when instr_valid & instr_ready at a rising edge.
//  - On transfer: instr_valid <= 0, pc <= pc+4 (32-bit, wraps mod 2^32), state <= BYTE0.
//  - No transfer: HOLD indefinitely with no memory reads.
//  - instr_valid is never dropped without a transfer, except on redirect or reset.
//  Latency: first instr_valid 4 cycles after reset deasserts; steady-state 1 instruction / 5 cycles
//   with instr_ready tied high.
//  Redirect (redirect_valid=1 at an edge, any state):
//  - pc <= {redirect_pc[31:2],2'b00}; state <= BYTE0; instr_valid <= 0.
//  - Partial bytes are discarded.
//  - Redirect beats the normal pc+4 update.
//  - If valid&ready coincide with a redirect, that instruction counts as transferred, then the
//    redirect applies.
//  - redirect_pc[1:0]!=0 sets align_err; align_err clears only on reset.
//  Reset mid-fetch: same as power-on reset; partial bytes discarded.
//  Address wrap: pc[31:ADDR_W] is kept and reported in instr_pc but not driven to memory.
//  - An aligned word never straddles the memory top.
// TESTING
//  1 mem[0..3]=8C,01,00,04; release reset, ready=1 -> cycle 4: valid=1, instr_out=8C010004, instr_pc=0
//  2 ready=0 for 10 cycles in HOLD -> instr_out stable, mem_rd_en=0; ready=1 -> next fetch at 0x04
//  3 redirect_pc=0x40 in BYTE2 -> partial dropped; 4 cycles later valid, instr_pc=0x40, mem[40..43] word
//  4 redirect_pc=0x42 -> fetch from 0x40, align_err=1 and stays 1 until reset
//  5 pc=0xFC, ADDR_W=8, accept -> instr_pc=0x100, mem_addr sequence 00,01,02,03
//  6 reset during BYTE1 -> next cycle valid=0, state BYTE0, mem_addr=RESET_PC[7:0]

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: assembles 32-bit big-endian instructions from a byte-wide
// memory with four sequential reads, then holds each one for decode under valid/ready.
module imem_fetch_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              align_err
);

  typedef enum logic [2:0] {
    BYTE0 = 3'd0,
    BYTE1 = 3'd1,
    BYTE2 = 3'd2,
    BYTE3 = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [7:0]        lane_reg [3];
  logic [2:0]        lane_en;
  logic [31:0]       instr_out_reg;
  logic [31:0]       instr_pc_reg;
  logic              instr_valid_reg;
  logic              align_err_reg;
  logic              transfer;
  logic [ADDR_W-1:0] byte_offset;

  assign transfer = instr_valid_reg & instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BYTE0;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // A redirect overrides both the byte sequence and the pc+4 advance.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BYTE0: state_next = BYTE1;
      BYTE1: state_next = BYTE2;
      BYTE2: state_next = BYTE3;
      BYTE3: state_next = HOLD;
      HOLD: begin
        if (transfer) begin
          state_next = BYTE0;
          pc_next    = pc_reg + 32'd4;
        end
      end
      default: state_next = BYTE0;
    endcase
    if (redirect_valid) begin
      state_next = BYTE0;
      pc_next    = {redirect_pc[31:2], 2'b00};
    end
  end

  always_comb begin
    mem_rd_en   = 1'b0;
    byte_offset = '0;
    case (state_reg)
      BYTE0: begin mem_rd_en = 1'b1; byte_offset = ADDR_W'(0); end
      BYTE1: begin mem_rd_en = 1'b1; byte_offset = ADDR_W'(1); end
      BYTE2: begin mem_rd_en = 1'b1; byte_offset = ADDR_W'(2); end
      BYTE3: begin mem_rd_en = 1'b1; byte_offset = ADDR_W'(3); end
      default: begin mem_rd_en = 1'b0; byte_offset = '0; end
    endcase
    mem_addr = pc_reg[ADDR_W-1:0] + byte_offset;
  end

  // Lanes 0..2 are latched as they arrive; lane 3 goes straight from mem_data into instr_out.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane_en
      assign lane_en[gi] = (state_reg == state_t'(3'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lane_en[i]) lane_reg[i] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out_reg   <= 32'h0;
      instr_pc_reg    <= 32'h0;
      instr_valid_reg <= 1'b0;
      align_err_reg   <= 1'b0;
    end else begin
      if (state_reg == BYTE3 && !redirect_valid) begin
        instr_out_reg   <= {lane_reg[0], lane_reg[1], lane_reg[2], mem_data};
        instr_pc_reg    <= pc_reg;
        instr_valid_reg <= 1'b1;
      end else if (transfer) begin
        instr_valid_reg <= 1'b0;
      end
      if (redirect_valid) begin
        instr_valid_reg <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) align_err_reg <= 1'b1;
      end
    end
  end

  assign instr_out   = instr_out_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign align_err   = align_err_reg;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios plus random traffic, all checked
// against a word-level model of the fetch stream.
module tb_imem_fetch_sequencer;

  localparam int unsigned  ADDR_W   = 8;
  localparam logic [31:0]  RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_data;
  logic [31:0]       instr_out;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              align_err;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  // Model: pc, how many of the current word's bytes have been read, and the held instruction.
  logic [31:0] m_pc;
  int          m_nbytes;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_align;

  imem_fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_data(mem_data), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .align_err(align_err)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [7:0] a;
    a = pc[7:0];
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (r) begin
      m_pc = RESET_PC; m_nbytes = 0; m_valid = 1'b0; m_align = 1'b0;
    end else begin
      if (m_nbytes < 4) begin
        m_nbytes++;
        if (m_nbytes == 4 && !rv) begin
          m_valid = 1'b1;
          m_ipc   = m_pc;
          m_instr = word_at(m_pc);
        end
      end else if (m_valid && rdy) begin
        m_valid  = 1'b0;
        m_pc     = m_pc + 32'd4;
        m_nbytes = 0;
      end
      if (rv) begin
        m_pc     = {rpc[31:2], 2'b00};
        m_nbytes = 0;
        m_valid  = 1'b0;
        if (rpc[1:0] != 2'b00) m_align = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [7:0] exp_addr;
    exp_addr = (m_nbytes < 4) ? 8'(m_pc[7:0] + 8'(m_nbytes)) : m_pc[7:0];
    chk("mem_rd_en", 32'(mem_rd_en), 32'(m_nbytes < 4));
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("align_err", 32'(align_err), 32'(m_align));
    if (m_valid) begin
      chk("instr_out", instr_out, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset = r; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    model_edge(r, rv, rpc, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h8C; mem[8'h01] = 8'h01; mem[8'h02] = 8'h00; mem[8'h03] = 8'h04;
    mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;
    m_pc = RESET_PC; m_nbytes = 0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_align = 1'b0;

    // Reset state and first-fetch latency
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("reset_instr_out", instr_out, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_not_yet_valid", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_instr", instr_out, 32'h8C010004);
    chk("t1_pc", instr_pc, 32'h0);

    // Stall in HOLD, then accept
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_stable", instr_out, 32'h8C010004);
    chk("t2_no_read", 32'(mem_rd_en), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_next_addr", 32'(mem_addr), 32'h04);
    chk("t2_valid_drop", 32'(instr_valid), 32'h0);

    // Redirect in BYTE2
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_instr", instr_out, 32'hDEADBEEF);
    chk("t3_pc", instr_pc, 32'h40);

    // Misaligned redirect coinciding with a transfer
    step(1'b0, 1'b1, 32'h42, 1'b1);
    chk("t4_addr", 32'(mem_addr), 32'h40);
    chk("t4_align", 32'(align_err), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t4_pc", instr_pc, 32'h40);
    chk("t4_align_sticky", 32'(align_err), 32'h1);

    // Address wrap past the memory top
    step(1'b0, 1'b1, 32'hFC, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_pc_fc", instr_pc, 32'hFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_addr0", 32'(mem_addr), 32'h00);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_addr1", 32'(mem_addr), 32'h01);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_addr2", 32'(mem_addr), 32'h02);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_addr3", 32'(mem_addr), 32'h03);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_pc_100", instr_pc, 32'h100);
    chk("t5_instr", instr_out, 32'h8C010004);

    // Reset during BYTE1
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_addr", 32'(mem_addr), 32'(RESET_PC[7:0]));
    chk("t6_rd_en", 32'(mem_rd_en), 32'h1);
    chk("t6_align", 32'(align_err), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rdy = ((i / 64) % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      step(r, rv, rpc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
